matmul_result_ctrl_module: RTL and testbench
============================================

// Module: matmul_result_ctrl_module
// PURPOSE
//  Downstream sequencer and result store for matrix_multiple_module.
//  - Launches one multiply on go_i and holds start_o high until finish_mul_i.
//  - Captures the flat C result and the overflow flags into a scratchpad slot.
//  - Feeds a selected slot back as the C bias (accumulate mode) and serves element reads.
// PARAMETERS
//  DATA_WIDTH      8   operand width (matches multiplier)
//  BUS_WIDTH       16  result element width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam)
//  SP_SLOTS        4   scratchpad slots, each MAX_DIM*MAX_DIM*BUS_WIDTH bits
//  TIMEOUT_CYCLES  16  max cycles in RUN before abort
// PORTS  (CW = MAX_DIM*MAX_DIM*BUS_WIDTH, EW = clog2(MAX_DIM*MAX_DIM), SW = clog2(SP_SLOTS))
//  clk_i          in   1                  clock
//  rst_ni         in   1                  async reset, active low
//  go_i           in   1                  request one multiply (sampled in IDLE only)
//  mode_bit_i     in   1                  0 = overwrite, 1 = accumulate onto bias slot
//  wr_slot_i      in   SW                 destination slot
//  bias_slot_i    in   SW                 slot driven on c_bias_o
//  start_o        out  1                  to multiplier start_i
//  mode_bit_o     out  1                  to multiplier mode_bit_i
//  c_bias_o       out  CW                 to multiplier c_matrix_i
//  finish_mul_i   in   1                  from multiplier finish_mul_o
//  c_matrix_i     in   CW                 from multiplier c_matrix_o
//  flags_i        in   MAX_DIM*MAX_DIM    from multiplier flags_o
//  rd_en_i        in   1                  element read strobe
//  rd_slot_i      in   SW                 read slot
//  rd_elem_i      in   EW                 read element index
//  rd_data_o      out  BUS_WIDTH          read data
//  rd_valid_o     out  1                  read data valid
//  flags_o        out  MAX_DIM*MAX_DIM    overflow flags of captured result
//  busy_o         out  1                  high in any state except IDLE
//  done_o         out  1                  one-cycle completion pulse
//  err_o          out  1                  timeout indicator
// BEHAVIOUR
//  - Reset: all outputs 0, every slot 0, state IDLE, timeout counter 0. Applies mid-operation; nothing is written.
//  - FSM IDLE -> RUN -> CAPTURE -> DONE -> IDLE.
//  - IDLE: go_i=1 latches mode_bit_i, wr_slot_i and bias_slot_i into registers and moves to RUN.
//    go_i is ignored in every other state (no queueing).
//  - RUN: start_o=1; mode_bit_o = latched mode; c_bias_o = slot[latched bias] when mode=1, else 0.
//    c_bias_o stays stable for the whole RUN state. The timeout counter increments once per cycle.
//  - RUN, finish_mul_i=1 on the first such cycle: go to CAPTURE and drop start_o (the multiplier self-clears).
//  - RUN, TIMEOUT_CYCLES elapsed with no finish: go to DONE with err_o=1; no slot or flag update.
//  - CAPTURE (1 cycle): slot[latched wr] <= c_matrix_i; flags_o <= flags_i; start_o=0.
//  - DONE (1 cycle): done_o=1 -> IDLE. err_o holds until the next accepted go_i.
//  - Latency for go_i(t) with finish_mul_i first seen at cycle f:
//    start_o high t+1..f; slot written at the f+1 edge; done_o at f+2.
//  - Read port: rd_en_i at t gives rd_data_o and rd_valid_o at t+1 (registered); rd_valid_o=0 otherwise.
//    rd_data_o holds its last value when not reading.
//  - Element e is bits [(e+1)*BUS_WIDTH-1 -: BUS_WIDTH] of the slot word, in the multiplier's flat
//    layout with no reordering. Out-of-range e (>= MAX_DIM^2) returns 0 with rd_valid_o=1.
//  - Reads are allowed in any state. A read of the slot being written in the CAPTURE cycle returns the old value.
//  - wr_slot == bias_slot is legal: the bias is read during RUN, the write happens in CAPTURE.
//  - finish_mul_i outside RUN is ignored.
// CONFIGURATION
//  MATMUL_STICKY_FLAGS_EN defined:
//    - CAPTURE does flags_o <= flags_o | flags_i.
//    - An accepted go_i with mode_bit_i=0 clears flags_o at the IDLE->RUN edge.
//  Undefined: CAPTURE replaces flags_o with flags_i.
// TESTING  (MAX_DIM=2, stub multiplier driving finish and C)
//  1. go, mode=0, wr=1; finish at RUN cycle 5, c={50,43,22,19} ->
//     done 2 cycles after finish; reads of slot1 e0..3 = 19,22,43,50.
//  2. Accumulate: slot1 loaded; go, mode=1, bias=1, wr=2 ->
//     c_bias_o equals slot1 throughout RUN; slot2 = stub C.
//  3. No finish -> start_o drops after 16 RUN cycles; done_o and err_o=1; slots unchanged; next go clears err_o.
//  4. go_i pulsed during RUN, and finish_mul_i pulsed in IDLE -> both ignored; exactly one done per accepted go.
//  5. rst_ni low mid-RUN -> start_o, busy_o and slots 0 asynchronously; clean op after release.
//  6. Flags 4'b0001 then 4'b0100 over two mode=1 ops -> flags_o 4'b0100, or 4'b0101 with MATMUL_STICKY_FLAGS_EN.

Source files
------------

// File: rtl/matmul_result_ctrl_module_if.sv
// Bus bundle for matmul_result_ctrl_module: go request, multiplier link, element read port and status.
// master = requester/multiplier side, slave = the result controller.
interface matmul_result_ctrl_module_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    parameter int SP_SLOTS   = 4
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int N_ELEM  = MAX_DIM * MAX_DIM;
    localparam int CW      = N_ELEM * BUS_WIDTH;
    localparam int SW      = (SP_SLOTS > 1) ? $clog2(SP_SLOTS) : 1;
    localparam int EW      = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    logic                 go_i;
    logic                 mode_bit_i;
    logic [SW-1:0]        wr_slot_i;
    logic [SW-1:0]        bias_slot_i;
    logic                 start_o;
    logic                 mode_bit_o;
    logic [CW-1:0]        c_bias_o;
    logic                 finish_mul_i;
    logic [CW-1:0]        c_matrix_i;
    logic [N_ELEM-1:0]    flags_i;
    logic                 rd_en_i;
    logic [SW-1:0]        rd_slot_i;
    logic [EW-1:0]        rd_elem_i;
    logic [BUS_WIDTH-1:0] rd_data_o;
    logic                 rd_valid_o;
    logic [N_ELEM-1:0]    flags_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;

    modport master (
        output go_i, mode_bit_i, wr_slot_i, bias_slot_i,
        output finish_mul_i, c_matrix_i, flags_i,
        output rd_en_i, rd_slot_i, rd_elem_i,
        input  start_o, mode_bit_o, c_bias_o,
        input  rd_data_o, rd_valid_o, flags_o, busy_o, done_o, err_o
    );

    modport slave (
        input  go_i, mode_bit_i, wr_slot_i, bias_slot_i,
        input  finish_mul_i, c_matrix_i, flags_i,
        input  rd_en_i, rd_slot_i, rd_elem_i,
        output start_o, mode_bit_o, c_bias_o,
        output rd_data_o, rd_valid_o, flags_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/matmul_result_ctrl_module.sv
// Sequencer and scratchpad result store for matrix_multiple_module (launch, capture, bias feedback, reads).
// Optional MATMUL_STICKY_FLAGS_EN: overflow flags accumulate across ops until an overwrite-mode go.
module matmul_result_ctrl_module #(
    parameter int DATA_WIDTH     = 8,
    parameter int BUS_WIDTH      = 16,
    parameter int SP_SLOTS       = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    matmul_result_ctrl_module_if.slave bus
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int N_ELEM  = MAX_DIM * MAX_DIM;
    localparam int CW      = N_ELEM * BUS_WIDTH;
    localparam int SW      = (SP_SLOTS > 1) ? $clog2(SP_SLOTS) : 1;
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [SW-1:0]        wr_slot_r;
    logic [CW-1:0]        slot_r [SP_SLOTS];
    logic                 start_r;
    logic                 mode_out_r;
    logic [CW-1:0]        c_bias_r;
    logic [N_ELEM-1:0]    flags_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;
    logic [BUS_WIDTH-1:0] rd_data_r;
    logic                 rd_valid_r;
    logic [31:0]          rd_idx_s;

    assign rd_idx_s = 32'(bus.rd_elem_i);

    // Sequencer: launch, wait for finish or timeout, capture into the scratchpad, pulse done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            wr_slot_r  <= '0;
            start_r    <= 1'b0;
            mode_out_r <= 1'b0;
            c_bias_r   <= '0;
            flags_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            for (int i = 0; i < SP_SLOTS; i++) begin
                slot_r[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.go_i) begin
                        wr_slot_r  <= bus.wr_slot_i;
                        mode_out_r <= bus.mode_bit_i;
                        // Bias is sampled once here; slots cannot change until CAPTURE,
                        // so c_bias_o stays stable for the whole RUN state.
                        c_bias_r   <= bus.mode_bit_i ? slot_r[bus.bias_slot_i] : '0;
                        start_r    <= 1'b1;
                        busy_r     <= 1'b1;
                        err_r      <= 1'b0;
                        cnt_r      <= '0;
                        state_r    <= ST_RUN;
`ifdef MATMUL_STICKY_FLAGS_EN
                        if (!bus.mode_bit_i) begin
                            flags_r <= '0;
                        end else begin
                            flags_r <= flags_r;
                        end
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (bus.finish_mul_i) begin
                        start_r    <= 1'b0;
                        mode_out_r <= 1'b0;
                        c_bias_r   <= '0;
                        state_r    <= ST_CAPTURE;
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        start_r    <= 1'b0;
                        mode_out_r <= 1'b0;
                        c_bias_r   <= '0;
                        err_r      <= 1'b1;
                        done_r     <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_CAPTURE: begin
                    slot_r[wr_slot_r] <= bus.c_matrix_i;
`ifdef MATMUL_STICKY_FLAGS_EN
                    flags_r <= flags_r | bus.flags_i;
`else
                    flags_r <= bus.flags_i;
`endif
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    start_r    <= 1'b0;
                    mode_out_r <= 1'b0;
                    c_bias_r   <= '0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered element read port; data holds between reads, CAPTURE-cycle reads see the old word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= bus.rd_en_i;
            if (bus.rd_en_i) begin
                if (rd_idx_s < 32'(N_ELEM)) begin
                    rd_data_r <= slot_r[bus.rd_slot_i][rd_idx_s * 32'(BUS_WIDTH) +: BUS_WIDTH];
                end else begin
                    rd_data_r <= '0;
                end
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign bus.start_o    = start_r;
    assign bus.mode_bit_o = mode_out_r;
    assign bus.c_bias_o   = c_bias_r;
    assign bus.flags_o    = flags_r;
    assign bus.busy_o     = busy_r;
    assign bus.done_o     = done_r;
    assign bus.err_o      = err_r;
    assign bus.rd_data_o  = rd_data_r;
    assign bus.rd_valid_o = rd_valid_r;
endmodule

// File: tb/tb_matmul_result_ctrl_module.sv
// Bench for matmul_result_ctrl_module (MAX_DIM=2): stub multiplier, cycle-level reference model, directed tests.
module tb_matmul_result_ctrl_module;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_ni;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    logic chk_en = 1'b0;

    matmul_result_ctrl_module_if #(.DATA_WIDTH(8), .BUS_WIDTH(16), .SP_SLOTS(4)) bus ();

    matmul_result_ctrl_module #(
        .DATA_WIDTH(8), .BUS_WIDTH(16), .SP_SLOTS(4), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: age counts cycles since an accepted go (-1 = idle); done_age fixes when done fires.
    int          m_age;
    int          m_done_age;
    logic        m_err;
    logic        m_mode;
    logic [1:0]  m_wr;
    logic [1:0]  m_bias;
    logic [3:0]  m_flags;
    logic [15:0] m_slot [4][4];
    logic        m_rv;
    logic [15:0] m_rd;
    logic [63:0] exp_bias;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_age <= -1; m_done_age <= 0; m_err <= 1'b0; m_mode <= 1'b0;
            m_wr <= 2'd0; m_bias <= 2'd0; m_flags <= 4'd0; m_rv <= 1'b0; m_rd <= 16'd0;
            for (int s = 0; s < 4; s++)
                for (int k = 0; k < 4; k++) m_slot[s][k] <= 16'd0;
        end else begin
            if (m_age < 0) begin
                if (bus.go_i) begin
                    m_age <= 1; m_done_age <= 0; m_err <= 1'b0;
                    m_mode <= bus.mode_bit_i; m_wr <= bus.wr_slot_i; m_bias <= bus.bias_slot_i;
`ifdef MATMUL_STICKY_FLAGS_EN
                    if (!bus.mode_bit_i) m_flags <= 4'd0;
`endif
                end
            end else if (m_done_age == 0) begin
                if (bus.finish_mul_i) m_done_age <= m_age + 2;
                else if (m_age == TIMEOUT) begin
                    m_done_age <= m_age + 1;
                    m_err <= 1'b1;
                end
                m_age <= m_age + 1;
            end else begin
                if (m_age == m_done_age - 1) begin
                    for (int k = 0; k < 4; k++) m_slot[m_wr][k] <= bus.c_matrix_i[k*16 +: 16];
`ifdef MATMUL_STICKY_FLAGS_EN
                    m_flags <= m_flags | bus.flags_i;
`else
                    m_flags <= bus.flags_i;
`endif
                end
                m_age <= (m_age == m_done_age) ? -1 : m_age + 1;
            end
            m_rv <= bus.rd_en_i;
            if (bus.rd_en_i) m_rd <= m_slot[bus.rd_slot_i][bus.rd_elem_i];
        end
    end

    // Per-cycle comparison of every output against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.done_o) done_cnt++;
        if (chk_en) begin
            chk("busy",     64'(bus.busy_o),     64'(m_age >= 1));
            chk("start",    64'(bus.start_o),    64'(m_age >= 1 && m_done_age == 0));
            chk("done",     64'(bus.done_o),     64'(m_age >= 1 && m_age == m_done_age));
            chk("err",      64'(bus.err_o),      64'(m_err));
            chk("flags",    64'(bus.flags_o),    64'(m_flags));
            chk("rd_valid", 64'(bus.rd_valid_o), 64'(m_rv));
            chk("rd_data",  64'(bus.rd_data_o),  64'(m_rd));
            if (m_age >= 1 && m_done_age == 0) begin
                for (int k = 0; k < 4; k++) exp_bias[k*16 +: 16] = m_mode ? m_slot[m_bias][k] : 16'd0;
                chk("mode_out", 64'(bus.mode_bit_o), 64'(m_mode));
                chk("c_bias",   bus.c_bias_o,        exp_bias);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic mode, input int wr, input int bias);
        bus.go_i = 1'b1; bus.mode_bit_i = mode;
        bus.wr_slot_i = 2'(wr); bus.bias_slot_i = 2'(bias);
        step();
        bus.go_i = 1'b0;
    endtask

    task automatic finish(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                          input logic [15:0] e3, input logic [3:0] fl);
        bus.finish_mul_i = 1'b1;
        bus.c_matrix_i = {e3, e2, e1, e0};
        bus.flags_i = fl;
        step();
        bus.finish_mul_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.busy_o && n < 40) begin
            step();
            n++;
        end
        chk(nm, 64'(bus.busy_o), 64'd0);
    endtask

    task automatic op(input logic mode, input int wr, input int bias, input int fin,
                      input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                      input logic [15:0] e3, input logic [3:0] fl);
        go(mode, wr, bias);
        repeat (fin - 1) step();
        finish(e0, e1, e2, e3, fl);
        wait_idle("op_idle");
    endtask

    task automatic rd(input int slot, input int elem, output logic [15:0] d);
        bus.rd_en_i = 1'b1; bus.rd_slot_i = 2'(slot); bus.rd_elem_i = 2'(elem);
        step();
        bus.rd_en_i = 1'b0;
        chk("rd_valid_lit", 64'(bus.rd_valid_o), 64'd1);
        d = bus.rd_data_o;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic [15:0] t1_exp [4];
        int n;
        int dn0;
        t1_exp[0] = 16'd19; t1_exp[1] = 16'd22; t1_exp[2] = 16'd43; t1_exp[3] = 16'd50;

        rst_ni = 1'b1;
        bus.go_i = 1'b0; bus.mode_bit_i = 1'b0; bus.wr_slot_i = 2'd0; bus.bias_slot_i = 2'd0;
        bus.finish_mul_i = 1'b0; bus.c_matrix_i = 64'd0; bus.flags_i = 4'd0;
        bus.rd_en_i = 1'b0; bus.rd_slot_i = 2'd0; bus.rd_elem_i = 2'd0;
        #3 rst_ni = 1'b0;
        step(); step();
        chk_en = 1'b1;
        chk("rst_busy",  64'(bus.busy_o),  64'd0);
        chk("rst_start", 64'(bus.start_o), 64'd0);
        chk("rst_done",  64'(bus.done_o),  64'd0);
        chk("rst_err",   64'(bus.err_o),   64'd0);
        chk("rst_flags", 64'(bus.flags_o), 64'd0);
        rst_ni = 1'b1;
        step();

        // 1: overwrite into slot1, finish on RUN cycle 5
        go(1'b0, 1, 0);
        repeat (4) begin
            chk("t1_start_run", 64'(bus.start_o), 64'd1);
            step();
        end
        chk("t1_start_run5", 64'(bus.start_o), 64'd1);
        finish(16'd19, 16'd22, 16'd43, 16'd50, 4'b0000);
        chk("t1_cap_start", 64'(bus.start_o), 64'd0);
        chk("t1_cap_done",  64'(bus.done_o),  64'd0);
        step();
        chk("t1_done_f2",   64'(bus.done_o),  64'd1);
        step();
        chk("t1_idle",      64'(bus.busy_o),  64'd0);
        for (int e = 0; e < 4; e++) begin
            rd(1, e, d);
            chk("t1_rd", 64'(d), 64'(t1_exp[e]));
        end

        // 2: accumulate with bias slot1 into slot2
        go(1'b1, 2, 1);
        chk("t2_bias_run1", bus.c_bias_o, 64'h0032_002B_0016_0013);
        chk("t2_mode_out",  64'(bus.mode_bit_o), 64'd1);
        step(); step();
        chk("t2_bias_run3", bus.c_bias_o, 64'h0032_002B_0016_0013);
        finish(16'd100, 16'd200, 16'd300, 16'd400, 4'b0000);
        wait_idle("t2_idle");
        rd(2, 3, d); chk("t2_rd_e3", 64'(d), 64'd400);
        rd(2, 0, d); chk("t2_rd_e0", 64'(d), 64'd100);

        // 3: timeout with no finish
        go(1'b0, 3, 0);
        n = 0;
        while (bus.start_o && n < 30) begin
            n++;
            step();
        end
        chk("t3_run_len", 64'(n), 64'd16);
        chk("t3_done", 64'(bus.done_o), 64'd1);
        chk("t3_err",  64'(bus.err_o),  64'd1);
        step();
        chk("t3_err_hold", 64'(bus.err_o), 64'd1);
        rd(3, 0, d); chk("t3_slot3", 64'(d), 64'd0);
        rd(1, 0, d); chk("t3_slot1", 64'(d), 64'd19);
        rd(2, 1, d); chk("t3_slot2", 64'(d), 64'd200);

        // 4: go during RUN and finish in IDLE are ignored
        dn0 = done_cnt;
        go(1'b0, 0, 0);
        chk("t4_err_clr", 64'(bus.err_o), 64'd0);
        step();
        bus.go_i = 1'b1;
        step();
        bus.go_i = 1'b0;
        step();
        finish(16'd5, 16'd6, 16'd7, 16'd8, 4'b0000);
        wait_idle("t4_idle");
        finish(16'd9, 16'd9, 16'd9, 16'd9, 4'b1111);
        repeat (5) step();
        chk("t4_dones", 64'(done_cnt - dn0), 64'd1);
        chk("t4_busy",  64'(bus.busy_o), 64'd0);
        rd(0, 1, d); chk("t4_slot0", 64'(d), 64'd6);

        // 5: asynchronous reset mid-RUN
        go(1'b0, 1, 0);
        step(); step();
        #1 rst_ni = 1'b0;
        #1;
        chk("t5_start", 64'(bus.start_o), 64'd0);
        chk("t5_busy",  64'(bus.busy_o),  64'd0);
        step(); step();
        rst_ni = 1'b1;
        step();
        rd(1, 0, d); chk("t5_slot1_clr", 64'(d), 64'd0);
        op(1'b0, 1, 0, 2, 16'd7, 16'd8, 16'd9, 16'd10, 4'b0000);
        rd(1, 2, d); chk("t5_slot1_new", 64'(d), 64'd9);

        // 6: overflow flags over two accumulate ops
        op(1'b1, 0, 3, 2, 16'd1, 16'd1, 16'd1, 16'd1, 4'b0001);
        chk("t6_flags1", 64'(bus.flags_o), 64'd1);
        op(1'b1, 0, 3, 3, 16'd2, 16'd2, 16'd2, 16'd2, 4'b0100);
`ifdef MATMUL_STICKY_FLAGS_EN
        chk("t6_flags2", 64'(bus.flags_o), 64'd5);
`else
        chk("t6_flags2", 64'(bus.flags_o), 64'd4);
`endif
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
